seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder.sv | 178 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed, active-low 7-segment scan into a hex frame value with dp mask.
// Optional frame watchdog enabled by defining SEG_DECODER_TIMEOUT_EN.
`default_nettype none

module seg_scan_decoder #(
  parameter int p_digits        = 8,
  parameter int p_settle_cycles = 4,
  parameter int p_timeout       = 65535
) (
  input  logic        i_w_clk,
  input  logic        i_w_reset,
  input  logic [7:0]  i_w_an,
  input  logic [7:0]  i_w_7_led_seg,
  output logic [31:0] o_r_value,
  output logic [7:0]  o_r_dp_mask,
  output logic        o_r_valid,
  output logic        o_r_error,
  output logic        o_r_timeout
);

  localparam logic [8:0] DIGIT_TOP   = 9'd1 << p_digits;
  localparam logic [7:0] DIGIT_MASK  = 8'(DIGIT_TOP - 9'd1);
  localparam logic [7:0] SETTLE_LAST = 8'(p_settle_cycles - 1);
  localparam logic [7:0] SETTLE_MAX  = 8'(p_settle_cycles);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_COMPLETE
  } state_t;

  state_t      state;
  logic [7:0]  an_q, seg_q, last_an, last_seg;
  logic [7:0]  settle_cnt;
  logic [7:0]  low_an, last_low_an;
  logic        one_low, stable, capture;
  logic [2:0]  cur_idx;
  logic [3:0]  dec_nib;
  logic        dec_ok;
  logic [7:0]  seen, ok_flags, seen_nx, ok_nx;
  logic        frame_full, all_ok, clear_frame, timeout_hit;
  logic [3:0]  shadow_nib [8];
  logic [7:0]  shadow_dp;
  logic [31:0] shadow_value;

  // Returns {ok, nibble}; patterns are active-low {g,f,e,d,c,b,a}.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'h40:   return {1'b1, 4'h0};
      7'h79:   return {1'b1, 4'h1};
      7'h24:   return {1'b1, 4'h2};
      7'h30:   return {1'b1, 4'h3};
      7'h19:   return {1'b1, 4'h4};
      7'h12:   return {1'b1, 4'h5};
      7'h02:   return {1'b1, 4'h6};
      7'h78:   return {1'b1, 4'h7};
      7'h00:   return {1'b1, 4'h8};
      7'h10:   return {1'b1, 4'h9};
      7'h08:   return {1'b1, 4'hA};
      7'h03:   return {1'b1, 4'hB};
      7'h46:   return {1'b1, 4'hC};
      7'h21:   return {1'b1, 4'hD};
      7'h06:   return {1'b1, 4'hE};
      7'h0E:   return {1'b1, 4'hF};
      default: return {1'b0, 4'h0};
    endcase
  endfunction

  // NOTE: every always_comb output gets a default before any conditional update so no latch is inferred.
  always_comb begin
    low_an      = ~an_q & DIGIT_MASK;
    last_low_an = ~last_an & DIGIT_MASK;
    one_low     = (low_an != 8'd0) && ((low_an & (low_an - 8'd1)) == 8'd0);
    cur_idx     = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (low_an[k]) cur_idx = 3'(k);
    end
    stable  = one_low && (low_an == last_low_an) && (seg_q == last_seg);
    capture = stable && (settle_cnt == SETTLE_LAST);
    {dec_ok, dec_nib} = decode_seg(seg_q[6:0]);
  end

  // A capture landing in the COMPLETE (or timeout) clock starts the next frame.
  always_comb begin
    clear_frame = (state == ST_COMPLETE) || timeout_hit;
    seen_nx     = clear_frame ? 8'd0 : seen;
    ok_nx       = clear_frame ? 8'd0 : ok_flags;
    if (capture) begin
      seen_nx[cur_idx] = 1'b1;
      ok_nx[cur_idx]   = dec_ok;
    end
    frame_full   = ((seen_nx & DIGIT_MASK) == DIGIT_MASK);
    all_ok       = ((ok_flags | ~DIGIT_MASK) == 8'hFF);
    shadow_value = 32'd0;
    for (int k = 0; k < 8; k++) begin
      if (DIGIT_MASK[k]) shadow_value[4*k +: 4] = shadow_nib[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      state       <= ST_IDLE;
      an_q        <= 8'hFF;
      seg_q       <= 8'hFF;
      last_an     <= 8'hFF;
      last_seg    <= 8'hFF;
      settle_cnt  <= 8'd0;
      seen        <= 8'd0;
      ok_flags    <= 8'd0;
      o_r_value   <= 32'd0;
      o_r_dp_mask <= 8'd0;
      o_r_valid   <= 1'b0;
      o_r_error   <= 1'b0;
    end else begin
      an_q     <= i_w_an;
      seg_q    <= i_w_7_led_seg;
      last_an  <= an_q;
      last_seg <= seg_q;

      if (!stable) settle_cnt <= 8'd0;
      else if (settle_cnt != SETTLE_MAX) settle_cnt <= settle_cnt + 8'd1;

      seen      <= seen_nx;
      ok_flags  <= ok_nx;
      o_r_valid <= 1'b0;
      o_r_error <= 1'b0;

      if (state == ST_COMPLETE) begin
        if (all_ok) begin
          o_r_value   <= shadow_value;
          o_r_dp_mask <= shadow_dp & DIGIT_MASK;
          o_r_valid   <= 1'b1;
        end else begin
          o_r_error <= 1'b1;
        end
      end

      if (capture) state <= frame_full ? ST_COMPLETE : ST_COLLECT;
      else if ((state == ST_COLLECT) && !timeout_hit) state <= ST_COLLECT;
      else state <= ST_IDLE;
    end
  end

  // NOTE: shadow digit storage is never read before being written within a frame, so it carries no reset.
  always_ff @(posedge i_w_clk) begin
    if (capture) begin
      shadow_nib[cur_idx] <= dec_nib;
      shadow_dp[cur_idx]  <= ~seg_q[7];
    end
  end

`ifdef SEG_DECODER_TIMEOUT_EN
  localparam int WD_W = (p_timeout < 2) ? 1 : $clog2(p_timeout + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(p_timeout - 1);

  logic [WD_W-1:0] wd_cnt;

  assign timeout_hit = (state == ST_COLLECT) && (wd_cnt == WD_LAST);

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      wd_cnt      <= '0;
      o_r_timeout <= 1'b0;
    end else begin
      o_r_timeout <= timeout_hit;
      if ((state == ST_COLLECT) && !timeout_hit) wd_cnt <= wd_cnt + WD_W'(1);
      else wd_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign o_r_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: expected frame results are queued as
// scans are driven and popped when the DUT pulses valid/error/timeout.
`timescale 1ns/1ps

module tb_seg_scan_decoder;

  localparam int P_DIGITS  = 8;
  localparam int P_SETTLE  = 4;
  localparam int P_TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  an  = 8'hFF;
  logic [7:0]  seg = 8'hFF;
  logic [31:0] o_r_value;
  logic [7:0]  o_r_dp_mask;
  logic        o_r_valid, o_r_error, o_r_timeout;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .p_digits       (P_DIGITS),
    .p_settle_cycles(P_SETTLE),
    .p_timeout      (P_TIMEOUT)
  ) dut (
    .i_w_clk      (clk),
    .i_w_reset    (rst),
    .i_w_an       (an),
    .i_w_7_led_seg(seg),
    .o_r_value    (o_r_value),
    .o_r_dp_mask  (o_r_dp_mask),
    .o_r_valid    (o_r_valid),
    .o_r_error    (o_r_error),
    .o_r_timeout  (o_r_timeout)
  );

  typedef enum logic [1:0] {K_VALID, K_ERROR, K_TIMEOUT} kind_t;
  typedef struct packed {
    kind_t       kind;
    logic [31:0] value;
    logic [7:0]  dp;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cycle    = 0;
  logic [31:0] model_value = 32'd0;
  logic [7:0]  model_dp    = 8'd0;

  logic [7:0] seg_of [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always @(posedge clk) cycle <= cycle + 1;

  // Scoreboard monitor: any output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && (o_r_valid || o_r_error || o_r_timeout)) begin
      exp_t  e;
      kind_t k;
      k = o_r_valid ? K_VALID : (o_r_error ? K_ERROR : K_TIMEOUT);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pulse: valid=%0b error=%0b timeout=%0b value=%h, required no pulse",
                 o_r_valid, o_r_error, o_r_timeout, o_r_value);
      end else begin
        e = exp_q.pop_front();
        if (($countones({o_r_valid, o_r_error, o_r_timeout}) != 1) || (k != e.kind))
          $display("FAIL pulse_kind: got valid=%0b error=%0b timeout=%0b, required kind %s",
                   o_r_valid, o_r_error, o_r_timeout, e.kind.name());
        else n_pass++;
        n_checks++;
        if (o_r_value !== e.value)
          $display("FAIL frame_value: got %h, required %h", o_r_value, e.value);
        else n_pass++;
        n_checks++;
        if (o_r_dp_mask !== e.dp)
          $display("FAIL frame_dp: got %h, required %h", o_r_dp_mask, e.dp);
        else n_pass++;
      end
    end
  end

  function automatic logic [7:0] enc(input logic [3:0] n, input logic dp);
    return seg_of[n] & (dp ? 8'h7F : 8'hFF);
  endfunction

  task automatic expect_pulse(input kind_t kind, input logic [31:0] value, input logic [7:0] dp);
    exp_t e;
    if (kind == K_VALID) begin
      model_value = value;
      model_dp    = dp;
    end
    e.kind  = kind;
    e.value = model_value;
    e.dp    = model_dp;
    exp_q.push_back(e);
  endtask

  // All drive tasks start and end on a falling edge.
  task automatic drive_digit(input int k, input logic [7:0] s, input int hold);
    logic [7:0] one;
    one = 8'd1;
    an  = ~(one << k);
    seg = s;
    repeat (hold) @(negedge clk);
  endtask

  task automatic scan_digits(input logic [31:0] val, input logic [7:0] dp,
                             input int first, input int last, input int hold);
    for (int k = first; k <= last; k++) drive_digit(k, enc(val[4*k +: 4], dp[k]), hold);
  endtask

  task automatic go_idle(input int n);
    an  = 8'hFF;
    seg = 8'hFF;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s_drain: %0d expected pulses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  task automatic check_outputs_zero(input string name);
    n_checks++;
    if (o_r_value !== 32'd0) $display("FAIL %s_value: got %h, required 0", name, o_r_value);
    else n_pass++;
    n_checks++;
    if (o_r_dp_mask !== 8'd0) $display("FAIL %s_dp: got %h, required 0", name, o_r_dp_mask);
    else n_pass++;
    n_checks++;
    if ({o_r_valid, o_r_error, o_r_timeout} !== 3'b000)
      $display("FAIL %s_pulses: got %b, required 000", name, {o_r_valid, o_r_error, o_r_timeout});
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    an  = 8'h00;
    seg = 8'h00;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_held");
    rst = 1'b0;
    go_idle(4);
    check_outputs_zero("reset_released");
  endtask

  task automatic test_basic_frame();
    expect_pulse(K_VALID, 32'h87654321, 8'h00);
    scan_digits(32'h87654321, 8'h00, 0, 7, 6);
    go_idle(8);
    drain("basic_frame");
  endtask

  task automatic test_error_frame();
    expect_pulse(K_ERROR, 32'd0, 8'd0);
    for (int k = 0; k < 8; k++)
      drive_digit(k, (k == 3) ? 8'hFF : enc(4'(k + 9), 1'b0), 6);
    go_idle(8);
    drain("error_frame");
  endtask

  task automatic test_settle();
    scan_digits(32'h2468ACE0, 8'h00, 0, 6, 6);
    drive_digit(7, enc(4'h2, 1'b0), 3);
    go_idle(12);
    expect_pulse(K_VALID, 32'h2468ACE0, 8'h00);
    drive_digit(7, enc(4'h2, 1'b0), 5);
    go_idle(8);
    drain("settle");
  endtask

  task automatic test_overwrite_multi_anode();
    expect_pulse(K_VALID, 32'h13579CDF, 8'h60);
    scan_digits(32'h13579BDF, 8'h60, 0, 3, 6);
    an  = 8'hFC;
    seg = 8'hC0;
    repeat (20) @(negedge clk);
    drive_digit(2, enc(4'hC, 1'b0), 6);
    scan_digits(32'h13579BDF, 8'h60, 4, 7, 6);
    go_idle(8);
    drain("overwrite_multi_anode");
  endtask

  task automatic test_reset_mid_frame();
    scan_digits(32'h11223344, 8'h00, 0, 3, 6);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_mid_frame");
    rst = 1'b0;
    model_value = 32'd0;
    model_dp    = 8'd0;
    go_idle(4);
    expect_pulse(K_VALID, 32'hDEADBEEF, 8'h01);
    for (int k = 7; k >= 0; k--)
      drive_digit(k, enc(4'(32'hDEADBEEF >> (4 * k)), k == 0), 6);
    go_idle(8);
    drain("reset_mid_frame");
  endtask

  task automatic test_back_to_back();
    expect_pulse(K_VALID, 32'h0F1E2D3C, 8'h81);
    expect_pulse(K_VALID, 32'hA5B6C7D8, 8'h3C);
    scan_digits(32'h0F1E2D3C, 8'h81, 0, 7, 5);
    scan_digits(32'hA5B6C7D8, 8'h3C, 0, 7, 5);
    go_idle(8);
    drain("back_to_back");
  endtask

  task automatic test_timeout();
`ifdef SEG_DECODER_TIMEOUT_EN
    int start_cycle;
    int waited;
    expect_pulse(K_TIMEOUT, 32'd0, 8'd0);
    start_cycle = cycle;
    scan_digits(32'h76543210, 8'h00, 0, 2, 6);
    an  = 8'hFF;
    seg = 8'hFF;
    waited = 0;
    while (!o_r_timeout && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (!o_r_timeout)
      $display("FAIL timeout_seen: no timeout pulse within bound, required one");
    else if (cycle != start_cycle + 6 + P_TIMEOUT)
      $display("FAIL timeout_cycle: got %0d, required %0d", cycle - start_cycle, 6 + P_TIMEOUT);
    else n_pass++;
    go_idle(8);
    drain("timeout");
`else
    int highs;
    expect_pulse(K_VALID, 32'h76543210, 8'h00);
    scan_digits(32'h76543210, 8'h00, 0, 2, 6);
    an  = 8'hFF;
    seg = 8'hFF;
    highs = 0;
    repeat (150) begin
      @(negedge clk);
      if (o_r_timeout) highs++;
    end
    n_checks++;
    if (highs != 0) $display("FAIL timeout_low: got %0d high clocks, required 0", highs);
    else n_pass++;
    scan_digits(32'h76543210, 8'h00, 3, 7, 6);
    go_idle(8);
    drain("collect_persists");
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_error_frame();
    test_settle();
    test_overwrite_multi_anode();
    test_reset_mid_frame();
    test_back_to_back();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
